// File: rtl/ark_keystore_pipe.sv
// Pipelined AddRoundKey stage with an integrated round-key store.
// Two register stages (key select, then XOR) under valid/ready flow control, one block per cycle.
module ark_keystore_pipe #(
  parameter int NR = 10,
  parameter int DW = 128,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_we,
  input  logic [AW-1:0] key_addr,
  input  logic [DW-1:0] key_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_state,
  input  logic [AW-1:0] in_round,
  input  logic          in_dec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_state,
  output logic          out_err,
  output logic          key_wr_err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NR);

  logic [DW-1:0] key_mem [NR+1];

  logic          s1_valid;
  logic [DW-1:0] s1_state;
  logic [DW-1:0] s1_key;
  logic          s1_err;

  logic          s2_adv;
  logic          s1_adv;
  logic          accept;
  logic          sel_err;
  logic [AW-1:0] sel_idx;
  logic [DW-1:0] sel_key;

  // in_ready is a function of pipeline occupancy only, never of in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !rst && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;

  assign sel_err = in_round > LAST_IDX;
  assign sel_idx = in_dec ? LAST_IDX - in_round : in_round;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_key = '0;
    if (!sel_err) begin
      for (int i = 0; i <= NR; i++) begin
        if (sel_idx == AW'(i)) sel_key = key_mem[i];
      end
    end
  end

  // NOTE: the key store is reset explicitly because a cleared store is part of the block's contract.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) key_mem[i] <= '0;
      key_wr_err <= 1'b0;
    end else begin
      key_wr_err <= key_we && (key_addr > LAST_IDX);
      for (int i = 0; i <= NR; i++) begin
        if (key_we && key_addr == AW'(i)) key_mem[i] <= key_in;
      end
    end
  end

  // NOTE: non-blocking assignments let a same-edge write and read see the old key without ordering hazards.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_state  <= '0;
      s1_key    <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_state <= '0;
      out_err   <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_state <= s1_state ^ s1_key;
          out_err   <= s1_err;
        end
      end

      if (accept) begin
        s1_valid <= 1'b1;
        s1_state <= in_state;
        s1_key   <= sel_key;
        s1_err   <= sel_err;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ark_keystore_pipe.sv
// Directed bench for ark_keystore_pipe: FIPS-197 AddRoundKey vectors, backpressure,
// write/read collision, range errors and mid-flight reset.
module tb_ark_keystore_pipe;

  localparam int NR = 10;
  localparam int DW = 128;
  localparam int AW = 4;

  localparam logic [DW-1:0] K0     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] K1     = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [DW-1:0] K1_NEW = 128'hff87968431d86a51645151fa773ad009;
  localparam logic [DW-1:0] K10    = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_we;
  logic [AW-1:0] key_addr;
  logic [DW-1:0] key_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_state;
  logic [AW-1:0] in_round;
  logic          in_dec;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_state;
  logic          out_err;
  logic          key_wr_err;

  int n_vec = 0;
  int n_err = 0;

  ark_keystore_pipe #(.NR(NR), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_we     (key_we),
    .key_addr   (key_addr),
    .key_in     (key_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .in_round   (in_round),
    .in_dec     (in_dec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_err    (out_err),
    .key_wr_err (key_wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic write_key(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    key_we   = 1'b1;
    key_addr = addr;
    key_in   = data;
    @(negedge clk);
    key_we   = 1'b0;
  endtask

  // Presents one block and holds it until accepted (bounded), then drops in_valid.
  task automatic send(input string tag, input logic [DW-1:0] st, input logic [AW-1:0] rnd, input logic dec);
    int budget;
    in_valid = 1'b1;
    in_state = st;
    in_round = rnd;
    in_dec   = dec;
    #1;
    budget = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_accept"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [DW-1:0] st, input logic err);
    int budget;
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_state"}, out_state, st);
    check({tag, "_err"}, out_err, err);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] blk [4];
    logic [DW-1:0] held;
    int n_acc;
    int n_out;

    rst = 1'b1; key_we = 1'b0; key_addr = '0; key_in = '0;
    in_valid = 1'b0; in_state = '0; in_round = '0; in_dec = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) blk[i] = {4{32'hc0de_0000 + 32'(i)}};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_state", out_state, '0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_key_wr_err", key_wr_err, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Back-to-back encrypt rounds 0 and 1, exact latency
    write_key(4'd0, K0);
    write_key(4'd1, K1);
    in_valid = 1'b1; in_state = 128'h000102030405060708090a0b0c0d0e0f; in_round = 4'd0; in_dec = 1'b0;
    @(negedge clk);
    in_state = 128'h5f72641557f5bc92f7be3b291db9f91a; in_round = 4'd1;
    check("lat_not_yet", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("r0_valid", out_valid, 1'b1);
    check("r0_state", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
    @(negedge clk);
    check("r1_valid", out_valid, 1'b1);
    check("r1_state", out_state, 128'h89d810e8855ace682d1843d8cb128fe4);
    check("r1_err", out_err, 1'b0);
    @(negedge clk);
    check("drain_idle", out_valid, 1'b0);

    // Decrypt mirror: round 0 with in_dec picks key[NR]
    write_key(4'd10, K10);
    send("dec", 128'h13111d7fe3944a17f307a78b4d2b30c5, 4'd0, 1'b1);
    expect_out("dec", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);

    // Top valid index in encrypt mode
    send("r10", 128'h0, 4'd10, 1'b0);
    expect_out("r10", K10, 1'b0);

    // Backpressure: stream 4 blocks into a stalled output
    out_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_state = blk[n_acc]; in_round = 4'd0; in_dec = 1'b0;
      #1;
      if (in_ready) n_acc++;
      @(negedge clk);
      if (c == 2) held = out_state;
    end
    check("bp_accepted", 128'(n_acc), 128'd2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_held", out_state, held);
    check("bp_head", out_state, blk[0] ^ K0);

    out_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (n_out < 4) check("bp_order", out_state, blk[n_out] ^ K0);
        n_out++;
      end
      in_valid = (n_acc < 4);
      if (n_acc < 4) in_state = blk[n_acc];
      #1;
      if (in_valid && in_ready) n_acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_out_count", 128'(n_out), 128'd4);

    // Same-cycle write and read of key[1]: old key first, new key next
    key_we = 1'b1; key_addr = 4'd1; key_in = K1_NEW;
    in_valid = 1'b1; in_state = 128'h5f72641557f5bc92f7be3b291db9f91a; in_round = 4'd1; in_dec = 1'b0;
    @(negedge clk);
    key_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("coll_old_state", out_state, 128'h89d810e8855ace682d1843d8cb128fe4);
    check("coll_old_valid", out_valid, 1'b1);
    @(negedge clk);
    check("coll_new_state", out_state, 128'ha0f5f291662dd6c393ef6ad36a832913);
    @(negedge clk);

    // Out-of-range round, both directions
    send("oor", 128'hdeadbeef_01234567_89abcdef_cafef00d, 4'd11, 1'b0);
    expect_out("oor", 128'hdeadbeef_01234567_89abcdef_cafef00d, 1'b1);
    send("oor_dec", 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0, 4'd15, 1'b1);
    expect_out("oor_dec", 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0, 1'b1);

    // Illegal key write pulses key_wr_err once and leaves the store intact
    write_key(4'd12, {DW{1'b1}});
    check("wr_err_pulse", key_wr_err, 1'b1);
    @(negedge clk);
    check("wr_err_clear", key_wr_err, 1'b0);
    send("store_k0", 128'h0, 4'd0, 1'b0);
    expect_out("store_k0", K0, 1'b0);
    write_key(4'd10, K10);
    check("wr_ok_no_err", key_wr_err, 1'b0);

    // Reset with both stages full
    out_ready = 1'b0;
    send("fill_a", blk[2], 4'd0, 1'b0);
    send("fill_b", blk[3], 4'd0, 1'b0);
    check("full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) n_out++;
      @(negedge clk);
    end
    check("no_stale_out", 128'(n_out), 128'd0);
    send("clr_k1", 128'h55aa55aa_11223344_55667788_99aabbcc, 4'd1, 1'b0);
    expect_out("clr_k1", 128'h55aa55aa_11223344_55667788_99aabbcc, 1'b0);
    send("clr_k10", 128'h0123456789abcdef0123456789abcdef, 4'd0, 1'b1);
    expect_out("clr_k10", 128'h0123456789abcdef0123456789abcdef, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
